controle_multiciclo: RTL
========================

# controle_multiciclo

Multi-cycle control unit that sequences a shared-resource MIPS datapath: one memory for instructions and data, one ALU for PC increment, branch target and execution. Each instruction is walked through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. The unit drives every mux select and write enable of the datapath, and stalls on a memory-ready handshake. It replaces the single-cycle `Controle` decoder when the datapath is built in its multi-cycle form.

## Interface
Parameters: none. All encodings are fixed in the shared package.
- clk  in  1  datapath clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26], taken from the instruction register
- zero  in  1  ALU zero flag, valid in the BRANCH state
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC load enable; already combines jump, branch and increment
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  2  register write data: 00 = ALUOut, 01 = MDR, 10 = PC
- RegDst  out  1  destination register: 0 = rt, 1 = rd
- selectRa  out  1  force destination register to $ra (5'd31)
- RegWrite  out  1  register bank write enable
- ALUSrcA  out  1  ALU input A: 0 = PC, 1 = rs
- ALUSrcB  out  2  ALU input B: 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2
- extendType  out  1  immediate extension: 1 = sign, 0 = zero
- ALUOp  out  4  operation code sent to ALUControl
- PCSource  out  2  next PC: 00 = ALU, 01 = ALUOut, 10 = jump address
- state  out  4  current state, for debug
- trap  out  1  sticky flag: an illegal opcode was decoded

## Operation
State register and encodings:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, JAL=12, TRAP=13.
- ALUOp codes: 0000 add, 0001 sub, 0010 funct (R-type), 0011 and, 0100 or, 0101 slt.

Per-state behaviour:
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - IRWrite and pc_en assert only while mem_ready=1; then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add, extendType=1 (branch target into ALUOut). Dispatch on opcode:
  - 000000 → EXEC_R
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) or 000101 (bne) → BRANCH
  - 000010 (j) → JUMP
  - 000011 (jal) → JAL
  - 001000 (addi), 001100 (andi), 001101 (ori), 001010 (slti) → EXEC_I
  - any other opcode → TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, extendType=1, ALUOp=add. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: IorD=1, MemRead=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=01, RegDst=0. Go to FETCH.
- MEM_WRITE: IorD=1, MemWrite=1. Hold until mem_ready, then go to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=funct. Go to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=00. Go to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. Settings by opcode:
  - addi: ALUOp=add, extendType=1
  - andi: ALUOp=and, extendType=0
  - ori: ALUOp=or, extendType=0
  - slti: ALUOp=slt, extendType=1
  - Then go to I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=00. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSource=01.
  - pc_en = zero for beq; pc_en = !zero for bne.
  - Go to FETCH.
- JUMP: PCSource=10, pc_en=1. Go to FETCH.
- JAL: PCSource=10, pc_en=1, RegWrite=1, selectRa=1, MemtoReg=10. The PC is still PC+4 during this cycle. Go to FETCH.
- TRAP: all enables 0, trap=1. Stays in TRAP until rst.

Defaults and decoding:
- Any output not listed for a state is 0 in that state.
- Outputs are combinational from state, opcode, zero and mem_ready. The registered opcode is stable from DECODE onward.

## Timing
- Reset (asynchronous): state=FETCH, trap=0.
  - While rst is high, pc_en, IRWrite, MemRead, MemWrite and RegWrite are forced to 0.
  - The first fetch starts on the first rising edge after rst falls.
- Cycles per instruction with zero memory waits:
  - R-type 4, lw 5, sw 4, I-arith 4
  - beq/bne 3, j 3, jal 3
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Strobes stay asserted and stable while waiting.
- Any memory strobe is held at most until the cycle where mem_ready=1 is sampled.
- rst asserted mid-instruction: all strobes drop immediately (combinationally), and the partial instruction is abandoned.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.

## Structure
- Package `controle_pkg` holds:
  - state localparams
  - opcode constants
  - ALUOp codes
  - MemtoReg, ALUSrcB and PCSource select codes
- One sub-module, `controle_saidas`: purely combinational output decode from state, opcode, zero and mem_ready.
- The top level holds the state register, next-state logic and the trap flag.

## Test plan
- lw with mem_ready=1: states 0,1,2,3,4,0. RegWrite=1 with MemtoReg=01 only in cycle 5. IRWrite only in cycle 1.
- FETCH with mem_ready low for 3 cycles: MemRead=1 for 4 cycles. IRWrite and pc_en pulse once, in the 4th cycle. State moves to DECODE afterwards.
- beq with zero=1 gives pc_en=1 in BRANCH. bne with zero=1 gives pc_en=0. bne with zero=0 gives pc_en=1. Each takes 3 cycles.
- jal: in JAL, RegWrite=1, selectRa=1, MemtoReg=10, PCSource=10, pc_en=1. Then FETCH.
- andi then addi: EXEC_I has extendType=0 with ALUOp=0011 (andi), then extendType=1 with ALUOp=0000 (addi).
- Opcode 111111 goes to TRAP: trap=1, no enables asserted for 10 cycles. rst raised mid-MEM_WRITE drops MemWrite in the same cycle. Both end in FETCH with trap=0 after reset.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// ALUOp codes and datapath mux select codes.
package controle_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    EXEC_I    = 4'd10,
    I_WB      = 4'd11,
    JAL       = 4'd12,
    TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // First execution state for each opcode; unknown opcodes land in TRAP.
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:                             return EXEC_R;
      OP_LW, OP_SW:                         return MEM_ADDR;
      OP_BEQ, OP_BNE:                       return BRANCH;
      OP_J:                                 return JUMP;
      OP_JAL:                               return JAL;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:    return EXEC_I;
      default:                              return TRAP;
    endcase
  endfunction

endpackage

// File: rtl/controle_saidas.sv
// Combinational datapath control decode from state, opcode, zero and mem_ready.
// Zero latency; stalls are expressed by holding strobes while mem_ready is low.
module controle_saidas
  import controle_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic       RegDst,
  output logic       selectRa,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       extendType,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource
);

  state_t st;
  assign st = state_t'(state);

  always_comb begin
    pc_en      = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = MTR_ALUOUT;
    RegDst     = 1'b0;
    selectRa   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RT;
    extendType = 1'b0;
    ALUOp      = ALU_ADD;
    PCSource   = PCS_ALU;

    case (st)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        pc_en   = mem_ready;
      end
      DECODE: begin
        // Speculative branch target into ALUOut.
        ALUSrcB    = SRCB_IMM_SH;
        extendType = 1'b1;
      end
      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        extendType = 1'b1;
      end
      MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = MTR_MDR;
      end
      MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_ANDI: begin ALUOp = ALU_AND; extendType = 1'b0; end
          OP_ORI:  begin ALUOp = ALU_OR;  extendType = 1'b0; end
          OP_SLTI: begin ALUOp = ALU_SLT; extendType = 1'b1; end
          default: begin ALUOp = ALU_ADD; extendType = 1'b1; end
        endcase
      end
      I_WB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = PCS_ALUOUT;
        pc_en    = (opcode == OP_BNE) ? ~zero : zero;
      end
      JUMP: begin
        PCSource = PCS_JUMP;
        pc_en    = 1'b1;
      end
      JAL: begin
        // PC still holds PC+4 here, so it is the link value.
        PCSource = PCS_JUMP;
        pc_en    = 1'b1;
        RegWrite = 1'b1;
        selectRa = 1'b1;
        MemtoReg = MTR_PC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS control FSM: state register, sequencing and sticky trap flag.
// Outputs are combinational; FETCH/MEM_READ/MEM_WRITE hold until mem_ready.
module controle_multiciclo
  import controle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic       RegDst,
  output logic       selectRa,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       extendType,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       trap
);

  state_t state_q, state_d;
  logic   trap_q;
  logic   pc_en_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == TRAP) trap_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (mem_ready) state_d = DECODE;
      DECODE:    state_d = dispatch(opcode);
      MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ready) state_d = MEM_WB;
      MEM_WRITE: if (mem_ready) state_d = FETCH;
      EXEC_R:    state_d = R_WB;
      EXEC_I:    state_d = I_WB;
      TRAP:      state_d = TRAP;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL: state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  controle_saidas u_saidas (
    .state      (state_q),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en_c),
    .IorD       (IorD),
    .MemRead    (mem_read_c),
    .MemWrite   (mem_write_c),
    .IRWrite    (ir_write_c),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .selectRa   (selectRa),
    .RegWrite   (reg_write_c),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .extendType (extendType),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource)
  );

  // Reset kills every enable immediately, even mid-access.
  assign pc_en    = pc_en_c     & ~rst;
  assign MemRead  = mem_read_c  & ~rst;
  assign MemWrite = mem_write_c & ~rst;
  assign IRWrite  = ir_write_c  & ~rst;
  assign RegWrite = reg_write_c & ~rst;
  assign state    = state_q;
  assign trap     = trap_q;

endmodule
